// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath: FSM states,
// default widths and a constant-evaluable clog2 for counter sizing.
package mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned ACC_W  = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / sum-out handshake bundle between the multiplier side and the
// accumulator; master is the producer/consumer, slave is the accumulator.
interface product_accumulator_if #(
    parameter int unsigned PROD_W = mac_pkg::PROD_W,
    parameter int unsigned ACC_W  = mac_pkg::ACC_W
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_p;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_overflow;
    logic              busy;

    modport master (
        output clear, in_valid, in_p, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow, busy
    );

    modport slave (
        input  clear, in_valid, in_p, out_ready,
        output in_ready, out_valid, out_sum, out_overflow, busy
    );
endinterface

// File: rtl/product_accumulator_acc_adder.sv
// Accumulator adder: ACC_W-bit sum of acc and zero-extended product,
// with the carry-out exposed for overflow tracking.
module acc_adder #(
    parameter int unsigned PROD_W = mac_pkg::PROD_W,
    parameter int unsigned ACC_W  = mac_pkg::ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] p,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] wide;

    always_comb begin
        wide  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
        sum   = wide[ACC_W-1:0];
        carry = wide[ACC_W];
    end
endmodule

// File: rtl/product_accumulator.sv
// Sums batches of COUNT_N multiplier products and presents each sum, with a
// sticky wrap-overflow flag, on a held valid/ready output.
module product_accumulator #(
    parameter int unsigned PROD_W  = mac_pkg::PROD_W,
    parameter int unsigned ACC_W   = mac_pkg::ACC_W,
    parameter int unsigned COUNT_N = 4
) (
    input logic                  clk,
    input logic                  rst,
    product_accumulator_if.slave bus
);
    import mac_pkg::*;

    localparam int unsigned CNT_W = clog2(COUNT_N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_N - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             deliver;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_acc_adder (
        .acc   (acc_q),
        .p     (bus.in_p),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Handshakes qualify on registered state only, so no input reaches an output.
    always_comb begin
        accept  = bus.in_valid && (state_q == ACCUM);
        deliver = bus.out_ready && (state_q == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_carry;
                    if (cnt_q == CNT_LAST) state_d = HOLD;
                end
            end
            HOLD: begin
                if (deliver) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
        // Abort overrides any accept or delivery in the same cycle.
        if (bus.clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_comb begin
        bus.in_ready     = (state_q == ACCUM);
        bus.out_valid    = (state_q == HOLD);
        bus.out_sum      = acc_q;
        bus.out_overflow = ovf_q;
        bus.busy         = (cnt_q != '0) || (state_q == HOLD);
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a 16-bit and a 9-bit accumulator
// instance share one driver, selected by sel9.
module tb_product_accumulator;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sel9;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_p;
    logic        out_ready;

    logic        in_ready_o;
    logic        out_valid_o;
    logic [15:0] out_sum_o;
    logic        out_ovf_o;
    logic        busy_o;

    int unsigned n_tests;
    int unsigned n_fail;
    exp_t        sb[$];

    product_accumulator_if #(.PROD_W(8), .ACC_W(16)) if16 ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(9))  if9 ();

    product_accumulator #(.PROD_W(8), .ACC_W(16), .COUNT_N(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT_N(4)) dut9 (
        .clk (clk),
        .rst (rst),
        .bus (if9)
    );

    assign if16.clear     = clear;
    assign if16.in_valid  = in_valid && !sel9;
    assign if16.in_p      = in_p;
    assign if16.out_ready = out_ready && !sel9;
    assign if9.clear      = clear;
    assign if9.in_valid   = in_valid && sel9;
    assign if9.in_p       = in_p;
    assign if9.out_ready  = out_ready && sel9;

    assign in_ready_o  = sel9 ? if9.in_ready     : if16.in_ready;
    assign out_valid_o = sel9 ? if9.out_valid    : if16.out_valid;
    assign out_sum_o   = sel9 ? {7'd0, if9.out_sum} : if16.out_sum;
    assign out_ovf_o   = sel9 ? if9.out_overflow : if16.out_overflow;
    assign busy_o      = sel9 ? if9.busy         : if16.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Model: W-bit wrapping sum of four products with sticky carry-out.
    task automatic push_batch(input int unsigned w, input int unsigned p0, input int unsigned p1,
                              input int unsigned p2, input int unsigned p3);
        int unsigned ps[4];
        int unsigned acc;
        int unsigned t;
        exp_t        e;
        ps = '{p0, p1, p2, p3};
        acc = 0;
        e.ovf = 1'b0;
        foreach (ps[i]) begin
            t = acc + ps[i];
            if (t >= (32'd1 << w)) begin
                e.ovf = 1'b1;
                t = t - (32'd1 << w);
            end
            acc = t;
        end
        e.sum = 16'(acc);
        sb.push_back(e);
    endtask

    task automatic send(input int unsigned p);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_p = 8'(p);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = in_ready_o;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send4(input int unsigned p0, input int unsigned p1,
                         input int unsigned p2, input int unsigned p3);
        send(p0);
        send(p1);
        send(p2);
        send(p3);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge clk);
            idle = !out_valid_o && !busy_o;
        end
        if (!idle) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Result is taken at the next edge when valid and ready are both seen here.
    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready && !clear) begin
            if (sb.size() == 0) begin
                check("sb_extra", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(out_sum_o), 32'(e.sum));
                check("ovf", 32'(out_ovf_o), 32'(e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        sel9 = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        in_p = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready_o), 1);
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_out_sum", 32'(out_sum_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic batch with latency check
        push_batch(16, 15, 225, 0, 100);
        send(15);
        send(225);
        send(0);
        check("pre_latency_valid", 32'(out_valid_o), 0);
        check("busy_mid_batch", 32'(busy_o), 1);
        send(100);
        check("latency_valid", 32'(out_valid_o), 1);
        check("hold_in_ready", 32'(in_ready_o), 0);
        @(posedge clk);
        #1;
        check("post_handshake_valid", 32'(out_valid_o), 0);
        check("post_handshake_busy", 32'(busy_o), 0);

        // Overflow on the 9-bit instance, then a clean batch
        sel9 = 1'b1;
        push_batch(9, 225, 225, 225, 225);
        send4(225, 225, 225, 225);
        push_batch(9, 1, 1, 1, 1);
        send4(1, 1, 1, 1);
        wait_idle();
        sel9 = 1'b0;

        // Back-pressure with a rejected product offered during HOLD
        out_ready = 1'b0;
        push_batch(16, 10, 20, 30, 40);
        send4(10, 20, 30, 40);
        in_valid = 1'b1;
        in_p = 8'd99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid_o), 1);
            check("bp_in_ready", 32'(in_ready_o), 0);
            check("bp_out_sum", 32'(out_sum_o), 100);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        push_batch(16, 1, 2, 3, 4);
        send4(1, 2, 3, 4);
        wait_idle();

        // Bubble, then clear colliding with a presented product
        push_batch(16, 1, 2, 3, 4);
        send(50);
        @(posedge clk);
        #1;
        send(60);
        clear = 1'b1;
        in_valid = 1'b1;
        in_p = 8'd7;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", 32'(busy_o), 0);
        send4(1, 2, 3, 4);
        wait_idle();

        // Clear while a result is held discards it even with out_ready high
        out_ready = 1'b0;
        send4(9, 9, 9, 9);
        clear = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_hold_valid", 32'(out_valid_o), 0);
        check("clear_hold_busy", 32'(busy_o), 0);

        // Asynchronous reset between edges mid-batch
        send(200);
        send(200);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_sum", 32'(out_sum_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        check("arst_in_ready", 32'(in_ready_o), 1);
        check("arst_out_valid", 32'(out_valid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_batch(16, 5, 5, 5, 5);
        send4(5, 5, 5, 5);
        wait_idle();

        // All 4x4 multiplier products in 64 batches
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b += 4) begin
                push_batch(16, a * b, a * (b + 1), a * (b + 2), a * (b + 3));
                send4(a * b, a * (b + 1), a * (b + 2), a * (b + 3));
            end
        end
        wait_idle();

        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
